// File: rtl/dds_pwm_multi_if.sv
// dds_pwm_multi_if: configuration write port (valid/ready) for the multi-channel DDS PWM generator
interface dds_pwm_multi_if #(
  parameter int CH_BITS    = 2,
  parameter int PHASE_BITS = 16
) ();
  logic                  valid;
  logic                  ready;
  logic [CH_BITS-1:0]    ch;
  logic [1:0]            mode;
  logic [PHASE_BITS-1:0] fcw;
  logic [PHASE_BITS-1:0] off;
  modport master (output valid, ch, mode, fcw, off, input ready);
  modport slave  (input valid, ch, mode, fcw, off, output ready);
endinterface

// File: rtl/dds_pwm_multi.sv
// dds_pwm_multi: multi-channel DDS phase accumulators driving PWM outputs, config committed at frame boundaries
module dds_pwm_multi #(
  parameter int NUM_CH     = 4,
  parameter int PHASE_BITS = 16,
  parameter int PWM_BITS   = 8,
  parameter int CH_BITS    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                en_in,
  input  logic                sync_in,
  dds_pwm_multi_if.slave      cfg,
  output logic                frame_tick_out,
  output logic [NUM_CH-1:0]   pwm_out
);
  localparam logic [PWM_BITS-1:0] MAX = '1;
  logic [PWM_BITS-1:0]   cnt;
  logic                  tick;
  logic                  pending;
  logic                  sync_pend;
  logic [CH_BITS-1:0]    sh_ch;
  logic [1:0]            sh_mode;
  logic [PHASE_BITS-1:0] sh_fcw;
  logic [PHASE_BITS-1:0] sh_off;
  logic                  xfer;
  assign tick      = en_in && (cnt == MAX);
  assign cfg.ready = ~pending;
  assign xfer      = cfg.valid && cfg.ready;
  // Frame counter, frame tick, single-slot config shadow and sticky resync request
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt            <= '0;
      frame_tick_out <= 1'b0;
      pending        <= 1'b0;
      sync_pend      <= 1'b0;
      sh_ch          <= '0;
      sh_mode        <= '0;
      sh_fcw         <= '0;
      sh_off         <= '0;
    end else begin
      cnt            <= en_in ? cnt + 1'b1 : cnt;
      frame_tick_out <= tick;
      sync_pend      <= sync_in || (sync_pend && !tick);
      if (tick && pending) pending <= 1'b0;
      else if (xfer) pending <= 1'b1;
      if (xfer) begin
        sh_ch   <= cfg.ch;
        sh_mode <= cfg.mode;
        sh_fcw  <= cfg.fcw;
        sh_off  <= cfg.off;
      end
    end
  end
  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic [PHASE_BITS-1:0] acc;
    logic [PHASE_BITS-1:0] fcw;
    logic [PHASE_BITS-1:0] off;
    logic [1:0]            mode;
    logic [PWM_BITS-1:0]   duty_q;
    logic                  pwm_q;
    logic [PHASE_BITS-1:0] p;
    logic [PWM_BITS-1:0]   s;
    logic [PWM_BITS-1:0]   t;
    logic [PWM_BITS-1:0]   w;
    logic                  hit;
    assign p   = acc + off;
    assign s   = p[PHASE_BITS-1 -: PWM_BITS];
    assign t   = {s[PWM_BITS-2:0], 1'b0};
    assign w   = (mode == 2'd0) ? s :
                 (mode == 2'd1) ? (p[PHASE_BITS-1] ? ~t : t) :
                 (mode == 2'd2) ? (p[PHASE_BITS-1] ? '0 : MAX) :
                 fcw[PWM_BITS-1:0];
    assign hit = pending && (sh_ch == CH_BITS'(n));
    assign pwm_out[n] = pwm_q;
    // Per-tick duty/phase update from pre-tick state, then commit of any shadowed write for this channel
    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        acc    <= '0;
        fcw    <= '0;
        off    <= '0;
        mode   <= '0;
        duty_q <= '0;
        pwm_q  <= 1'b0;
      end else begin
        pwm_q <= en_in && (cnt < duty_q);
        if (tick) begin
          duty_q <= w;
          acc    <= sync_pend ? '0 : acc + fcw;
          if (hit) begin
            mode <= sh_mode;
            fcw  <= sh_fcw;
            off  <= sh_off;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_dds_pwm_multi.sv
// tb_dds_pwm_multi: directed self-checking bench for dds_pwm_multi
module tb_dds_pwm_multi;
  localparam int NUM_CH = 4;
  logic              clk_in = 1'b0;
  logic              rst_in = 1'b0;
  logic              en_in = 1'b0;
  logic              sync_in = 1'b0;
  logic              frame_tick_out;
  logic [NUM_CH-1:0] pwm_out;
  int cmp_n = 0;
  int err_n = 0;
  int hc [NUM_CH];
  dds_pwm_multi_if #(.CH_BITS(2), .PHASE_BITS(16)) cfg ();
  dds_pwm_multi #(.NUM_CH(NUM_CH), .PHASE_BITS(16), .PWM_BITS(8)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .en_in(en_in),
    .sync_in(sync_in),
    .cfg(cfg),
    .frame_tick_out(frame_tick_out),
    .pwm_out(pwm_out)
  );
  always #5 clk_in = ~clk_in;
  task automatic wait_tick();
    int n = 0;
    @(negedge clk_in);
    while (frame_tick_out !== 1'b1 && n < 600) begin
      @(negedge clk_in);
      n++;
    end
    if (frame_tick_out !== 1'b1) begin
      cmp_n++;
      err_n++;
      $display("FAIL tick_timeout: frame_tick_out=%b required 1", frame_tick_out);
    end
  endtask
  task automatic measure();
    if (frame_tick_out !== 1'b1) wait_tick();
    for (int c = 0; c < NUM_CH; c++) hc[c] = 0;
    repeat (256) begin
      for (int c = 0; c < NUM_CH; c++) hc[c] += (pwm_out[c] === 1'b1) ? 1 : 0;
      @(negedge clk_in);
    end
  endtask
  task automatic cfg_write(input logic [1:0] ch, input logic [1:0] mode,
                           input logic [15:0] fcw, input logic [15:0] off, output int waited);
    waited = 0;
    @(negedge clk_in);
    cfg.valid = 1'b1;
    cfg.ch    = ch;
    cfg.mode  = mode;
    cfg.fcw   = fcw;
    cfg.off   = off;
    while (cfg.ready !== 1'b1 && waited < 1000) begin
      @(negedge clk_in);
      waited++;
    end
    if (cfg.ready !== 1'b1) begin
      cmp_n++;
      err_n++;
      $display("FAIL cfg_timeout: ready=%b required 1", cfg.ready);
    end
    @(negedge clk_in);
    cfg.valid = 1'b0;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk_in);
    cmp_n++; if (pwm_out !== 4'h0) begin err_n++; $display("FAIL reset_pwm: got %h want 0", pwm_out); end
    cmp_n++; if (frame_tick_out !== 1'b0) begin err_n++; $display("FAIL reset_tick: got %b want 0", frame_tick_out); end
    cmp_n++; if (cfg.ready !== 1'b1) begin err_n++; $display("FAIL reset_ready: got %b want 1", cfg.ready); end
    rst_in = 1'b1;
    en_in  = 1'b1;
  endtask
  task automatic test_idle();
    measure();
    cmp_n++; if (hc[0] + hc[1] + hc[2] + hc[3] != 0) begin err_n++; $display("FAIL idle_pwm: got %0d high cycles want 0", hc[0] + hc[1] + hc[2] + hc[3]); end
    cmp_n++; if (frame_tick_out !== 1'b1) begin err_n++; $display("FAIL idle_period: tick=%b want 1 after 256 cycles", frame_tick_out); end
    cmp_n++; if (cfg.ready !== 1'b1) begin err_n++; $display("FAIL idle_ready: got %b want 1", cfg.ready); end
  endtask
  task automatic test_saw();
    int w;
    int exp_d [5] = '{0, 0, 1, 2, 3};
    cfg_write(2'd0, 2'd0, 16'h0100, 16'h0000, w);
    cmp_n++; if (cfg.ready !== 1'b0) begin err_n++; $display("FAIL saw_ready_low: got %b want 0", cfg.ready); end
    wait_tick();
    cmp_n++; if (cfg.ready !== 1'b1) begin err_n++; $display("FAIL saw_ready_back: got %b want 1", cfg.ready); end
    for (int k = 0; k < 5; k++) begin
      measure();
      cmp_n++; if (hc[0] != exp_d[k]) begin err_n++; $display("FAIL saw_frame%0d: got %0d want %0d", k, hc[0], exp_d[k]); end
    end
  endtask
  task automatic test_back_to_back();
    int w1, w2;
    cfg_write(2'd1, 2'd3, 16'h0040, 16'h0000, w1);
    cmp_n++; if (cfg.ready !== 1'b0) begin err_n++; $display("FAIL b2b_ready_low: got %b want 0", cfg.ready); end
    cfg_write(2'd2, 2'd3, 16'h00FF, 16'h0000, w2);
    cmp_n++; if (w2 < 200) begin err_n++; $display("FAIL b2b_stall: waited %0d cycles want >=200", w2); end
    wait_tick();
    measure();
    measure();
    cmp_n++; if (hc[1] != 64) begin err_n++; $display("FAIL b2b_ch1: got %0d want 64", hc[1]); end
    cmp_n++; if (hc[2] != 255) begin err_n++; $display("FAIL b2b_ch2: got %0d want 255", hc[2]); end
    cmp_n++; if (hc[0] != 7) begin err_n++; $display("FAIL b2b_ch0: got %0d want 7", hc[0]); end
    cmp_n++; if (hc[3] != 0) begin err_n++; $display("FAIL b2b_ch3: got %0d want 0", hc[3]); end
  endtask
  task automatic test_square();
    int w;
    int exp_a [3] = '{255, 0, 255};
    int exp_b [3] = '{255, 255, 0};
    cfg_write(2'd3, 2'd2, 16'h8000, 16'h0000, w);
    wait_tick();
    measure();
    for (int k = 0; k < 3; k++) begin
      measure();
      cmp_n++; if (hc[3] != exp_a[k]) begin err_n++; $display("FAIL square_frame%0d: got %0d want %0d", k, hc[3], exp_a[k]); end
    end
    cfg_write(2'd3, 2'd2, 16'h8000, 16'h8000, w);
    wait_tick();
    for (int k = 0; k < 3; k++) begin
      measure();
      cmp_n++; if (hc[3] != exp_b[k]) begin err_n++; $display("FAIL square_off_frame%0d: got %0d want %0d", k, hc[3], exp_b[k]); end
    end
  endtask
  task automatic test_sync();
    int w;
    int exp_s [3] = '{18, 0, 1};
    int exp_c0 [3] = '{3, 0, 1};
    int exp_c1 [3] = '{64, 64, 66};
    repeat (100) @(negedge clk_in);
    sync_in = 1'b1;
    @(negedge clk_in);
    sync_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      measure();
      cmp_n++; if (hc[0] != exp_s[k]) begin err_n++; $display("FAIL sync_frame%0d: got %0d want %0d", k, hc[0], exp_s[k]); end
    end
    cfg_write(2'd1, 2'd0, 16'h0200, 16'h4000, w);
    sync_in = 1'b1;
    @(negedge clk_in);
    sync_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      measure();
      cmp_n++; if (hc[0] != exp_c0[k]) begin err_n++; $display("FAIL sync_commit_ch0_frame%0d: got %0d want %0d", k, hc[0], exp_c0[k]); end
      cmp_n++; if (hc[1] != exp_c1[k]) begin err_n++; $display("FAIL sync_commit_ch1_frame%0d: got %0d want %0d", k, hc[1], exp_c1[k]); end
    end
  endtask
  task automatic test_triangle();
    int w;
    int exp_t [4] = '{70, 198, 185, 57};
    cfg_write(2'd2, 2'd1, 16'h4000, 16'h2000, w);
    wait_tick();
    measure();
    for (int k = 0; k < 4; k++) begin
      measure();
      cmp_n++; if (hc[2] != exp_t[k]) begin err_n++; $display("FAIL tri_frame%0d: got %0d want %0d", k, hc[2], exp_t[k]); end
    end
  endtask
  task automatic test_reset_mid();
    int w;
    cfg_write(2'd0, 2'd3, 16'h0080, 16'h0000, w);
    repeat (50) @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    cmp_n++; if (pwm_out !== 4'h0) begin err_n++; $display("FAIL rstmid_pwm: got %h want 0", pwm_out); end
    cmp_n++; if (cfg.ready !== 1'b1) begin err_n++; $display("FAIL rstmid_ready: got %b want 1", cfg.ready); end
    cmp_n++; if (frame_tick_out !== 1'b0) begin err_n++; $display("FAIL rstmid_tick: got %b want 0", frame_tick_out); end
    @(negedge clk_in);
    rst_in = 1'b1;
    for (int k = 0; k < 2; k++) begin
      measure();
      cmp_n++; if (hc[0] + hc[1] + hc[2] + hc[3] != 0) begin err_n++; $display("FAIL rstmid_frame%0d: got %0d high cycles want 0", k, hc[0] + hc[1] + hc[2] + hc[3]); end
    end
  endtask
  task automatic test_enable();
    int w;
    int ticks = 0;
    cfg_write(2'd1, 2'd3, 16'h0080, 16'h0000, w);
    wait_tick();
    wait_tick();
    repeat (10) @(negedge clk_in);
    cmp_n++; if (pwm_out[1] !== 1'b1) begin err_n++; $display("FAIL en_pwm_high: got %b want 1", pwm_out[1]); end
    en_in = 1'b0;
    @(negedge clk_in);
    cmp_n++; if (pwm_out !== 4'h0) begin err_n++; $display("FAIL en_off_pwm: got %h want 0", pwm_out); end
    repeat (300) begin
      @(negedge clk_in);
      ticks += (frame_tick_out === 1'b1) ? 1 : 0;
    end
    cmp_n++; if (ticks != 0) begin err_n++; $display("FAIL en_off_ticks: got %0d want 0", ticks); end
    en_in = 1'b1;
  endtask
  initial begin
    cfg.valid = 1'b0;
    cfg.ch    = '0;
    cfg.mode  = '0;
    cfg.fcw   = '0;
    cfg.off   = '0;
    test_reset();
    test_idle();
    test_saw();
    test_back_to_back();
    test_square();
    test_sync();
    test_triangle();
    test_reset_mid();
    test_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
